// File: rtl/o_ddr_serializer.sv
// Parallel-to-DDR output serializer: one-word holding register feeding a shift
// register that emits two bits per clock, LSB-first, with no gap between words.
module o_ddr_serializer #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             C,
    input  logic             R,
    input  logic             E,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             DATA_VALID,
    output logic             DATA_READY,
    output logic [1:0]       Q,
    output logic             FRAME,
    output logic             BUSY
);

    localparam int HALF = WIDTH / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    generate
        if (WIDTH < 4 || WIDTH > 16 || (WIDTH % 2) != 0) begin : g_bad_width
            $error("o_ddr_serializer: WIDTH must be even and within 4..16");
        end
    endgenerate

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] hold, shr, shr_nxt;
    logic             hold_full, hold_full_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [1:0]       q_nxt;
    logic             frame_nxt;
    logic             load;
    logic             accept;

    assign DATA_READY = R & E & ~hold_full;
    assign accept     = DATA_VALID & DATA_READY;

    // cnt is the index of the next pair to emit; 0 while in SHIFT means the
    // last pair of the current word is already on Q.
    always_comb begin
        state_nxt     = state;
        shr_nxt       = shr;
        cnt_nxt       = cnt;
        q_nxt         = Q;
        frame_nxt     = 1'b0;
        hold_full_nxt = hold_full;
        load          = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) load = 1'b1;
                else           q_nxt = {2{IDLE_LEVEL}};
            end
            SHIFT: begin
                if (cnt != '0) begin
                    q_nxt   = shr[{cnt, 1'b0} +: 2];
                    cnt_nxt = (cnt == CW'(HALF - 1)) ? '0 : cnt + 1'b1;
                end else if (hold_full) begin
                    load = 1'b1;
                end else begin
                    q_nxt     = {2{IDLE_LEVEL}};
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (load) begin
            shr_nxt       = hold;
            q_nxt         = hold[1:0];
            frame_nxt     = 1'b1;
            cnt_nxt       = CW'(1);
            state_nxt     = SHIFT;
            hold_full_nxt = 1'b0;
        end
        // READY is low while HOLD is full, so this never collides with load.
        if (accept) hold_full_nxt = 1'b1;
    end

    always_ff @(posedge C) begin
        if (!R) begin
            state     <= IDLE;
            Q         <= {2{IDLE_LEVEL}};
            FRAME     <= 1'b0;
            BUSY      <= 1'b0;
            hold_full <= 1'b0;
            cnt       <= '0;
        end else if (E) begin
            state     <= state_nxt;
            Q         <= q_nxt;
            FRAME     <= frame_nxt;
            BUSY      <= (state_nxt == SHIFT);
            hold_full <= hold_full_nxt;
            cnt       <= cnt_nxt;
            shr       <= shr_nxt;
            if (accept) hold <= DATA_IN;
        end
    end

endmodule

// File: tb/tb_o_ddr_serializer.sv
// Scoreboard bench for o_ddr_serializer: accepted words are expanded into
// expected (pair, frame, earliest-cycle) entries that a monitor pops per edge.
module tb_o_ddr_serializer;

    localparam int   W    = 8;
    localparam int   HALF = W / 2;
    localparam logic IDL  = 1'b0;

    logic         C = 1'b0, R = 1'b0, E = 1'b1, DV = 1'b0;
    logic [W-1:0] DI = '0;
    logic         DATA_READY;
    logic [1:0]   Q;
    logic         FRAME, BUSY;

    o_ddr_serializer #(.WIDTH(W), .IDLE_LEVEL(IDL)) dut (
        .C(C), .R(R), .E(E), .DATA_IN(DI), .DATA_VALID(DV),
        .DATA_READY(DATA_READY), .Q(Q), .FRAME(FRAME), .BUSY(BUSY)
    );

    always #5 C = ~C;

    typedef struct {
        logic [1:0]  q;
        logic        fr;
        int unsigned rdy;
    } ent_t;

    ent_t        exq[$];
    ent_t        e;
    int          checks = 0, errors = 0;
    int unsigned cyc = 0;
    int          pend = 0;
    int unsigned acc_log[$];
    bit          log_acc = 0;
    logic        s_r, s_e, s_dv, s_rdy;
    logic [W-1:0] s_di;
    logic [1:0]  pq = '0;
    logic        pf = 1'b0, pb = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / reference model: inputs sampled at the edge, outputs 1 time unit later.
    always begin
        @(posedge C);
        s_r = R; s_e = E; s_dv = DV; s_rdy = DATA_READY; s_di = DI;
        if (!s_r || !s_e) chk("ready_low", {31'd0, s_rdy}, 0);
        else              chk("ready", {31'd0, s_rdy}, {31'd0, pend == 0});
        #1;
        if (!s_r) begin
            exq.delete();
            pend = 0;
            chk("rst_q", {30'd0, Q}, {30'd0, {2{IDL}}});
            chk("rst_busy", {31'd0, BUSY}, 0);
            chk("rst_frame", {31'd0, FRAME}, 0);
        end else if (!s_e) begin
            chk("freeze_q", {30'd0, Q}, {30'd0, pq});
            chk("freeze_frame", {31'd0, FRAME}, {31'd0, pf});
            chk("freeze_busy", {31'd0, BUSY}, {31'd0, pb});
        end else begin
            cyc++;
            if (s_dv && s_rdy) begin
                pend++;
                for (int k = 0; k < HALF; k++)
                    exq.push_back('{q: s_di[2*k +: 2], fr: (k == 0), rdy: cyc + 1});
                if (log_acc) acc_log.push_back(cyc);
            end
            if (exq.size() > 0 && exq[0].rdy <= cyc) begin
                e = exq.pop_front();
                if (e.fr) pend--;
                chk("q", {30'd0, Q}, {30'd0, e.q});
                chk("frame", {31'd0, FRAME}, {31'd0, e.fr});
                chk("busy", {31'd0, BUSY}, 1);
            end else begin
                chk("idle_q", {30'd0, Q}, {30'd0, {2{IDL}}});
                chk("idle_frame", {31'd0, FRAME}, 0);
                chk("idle_busy", {31'd0, BUSY}, 0);
            end
        end
        pq = Q; pf = FRAME; pb = BUSY;
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [W-1:0] w);
        int t;
        DV = 1'b1; DI = w; t = 0;
        #1;
        while (!DATA_READY && t < 200) begin
            @(negedge C); #1; t++;
        end
        if (t >= 200) begin
            checks++; errors++;
            $display("FAIL send_timeout: ready never rose within %0d cycles", t);
        end
        @(negedge C);
    endtask

    task automatic idle(input int n);
        DV = 1'b0;
        repeat (n) @(negedge C);
    endtask

    initial begin
        R = 1'b0; E = 1'b1;
        repeat (3) @(negedge C);
        R = 1'b1;
        idle(2);

        // single word, then back-to-back pair
        send(8'hB4); idle(8);
        send(8'hB4); send(8'h1E); idle(8);

        // sustained valid: accept spacing must settle to one word per HALF cycles
        log_acc = 1;
        for (int i = 0; i < 16; i++) send(W'($urandom));
        idle(HALF * 3);
        log_acc = 0;
        chk("bp_words", acc_log.size(), 16);
        for (int i = 1; i < acc_log.size(); i++)
            chk("bp_spacing", acc_log[i] - acc_log[i-1], (i == 1) ? 2 : HALF);

        // enable stall after pair 1
        send(8'hB4); DV = 1'b0;
        @(negedge C);
        @(negedge C);
        E = 1'b0;
        repeat (3) @(negedge C);
        chk("stall_q", {30'd0, Q}, 2'b01);
        E = 1'b1;
        idle(6);

        // reset after pair 2
        send(8'hB4); DV = 1'b0;
        repeat (3) @(negedge C);
        R = 1'b0;
        #1 chk("rst_ready", {31'd0, DATA_READY}, 0);
        @(negedge C);
        chk("rst_mid_q", {30'd0, Q}, 0);
        chk("rst_mid_busy", {31'd0, BUSY}, 0);
        R = 1'b1;
        send(8'hFF); idle(8);

        // underrun: second word offered two cycles after the last pair
        send(8'hB4); idle(5);
        send(8'h1E); idle(8);

        // random traffic with stalls and occasional resets
        for (int i = 0; i < 500; i++) begin
            R  = ($urandom_range(0, 49) != 0);
            E  = ($urandom_range(0, 7) != 0);
            DV = $urandom_range(0, 1);
            DI = W'($urandom);
            @(negedge C);
        end
        R = 1'b1; E = 1'b1;
        idle(HALF * 4);
        chk("drain", exq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/o_ddr_serializer.md
O_DDR_SERIALIZER -- requirements
Module: O_DDR_SERIALIZER

Interface
REQ-001 SHALL have parameter WIDTH, default 8; parallel word width; legal values: even, 4..16; any other value is an elaboration error.
REQ-002 SHALL have parameter IDLE_LEVEL, default 1'b0; value driven on both Q bits when no word is shifting.
REQ-003 SHALL have port C, input, 1 bit; the single clock; all state updates on its rising edge.
REQ-004 SHALL have port R, input, 1 bit; reset, synchronous and active-low.
REQ-005 SHALL have port E, input, 1 bit; active-high enable; low = freeze all state.
REQ-006 SHALL have port DATA_IN, input, WIDTH bits; parallel word to transmit.
REQ-007 SHALL have port DATA_VALID, input, 1 bit; DATA_IN is valid.
REQ-008 SHALL have port DATA_READY, output, 1 bit; block can accept a word this cycle.
REQ-009 SHALL have port Q, output, 2 bits, registered; DDR pair for the output pad: Q[0] = rising-half bit, Q[1] = falling-half bit.
REQ-010 SHALL have port FRAME, output, 1 bit, registered; high while Q carries pair 0 of a word.
REQ-011 SHALL have port BUSY, output, 1 bit, registered; high in state SHIFT.

Function
REQ-012 SHALL contain a one-entry holding register (HOLD) with a full flag, a WIDTH-bit shift register (SHR), a pair counter 0..WIDTH/2-1, and a two-state FSM: IDLE, SHIFT.
REQ-013 SHALL drive DATA_READY = R & E & !HOLD_full, combinationally.
REQ-014 SHALL accept a word on a rising edge where DATA_VALID & DATA_READY; DATA_IN is written into HOLD and HOLD_full is set.
REQ-015 SHALL ignore DATA_VALID when DATA_READY is low; DATA_IN is not sampled.
REQ-016 IDLE with HOLD_full: next edge SHALL load SHR from HOLD, clear HOLD_full, set Q = {HOLD[1],HOLD[0]}, FRAME=1, counter=1, and enter SHIFT.
REQ-017 IDLE with HOLD empty: Q SHALL hold {IDLE_LEVEL,IDLE_LEVEL}, FRAME=0, BUSY=0.
REQ-018 SHIFT with counter k < WIDTH/2: edge SHALL set Q = {SHR[2k+1],SHR[2k]}, FRAME=0, and increment the counter. Bit order is LSB-first.
REQ-019 SHIFT after the last pair has been emitted, with HOLD_full: edge SHALL reload per REQ-016 and stay in SHIFT. There is no gap between words.
REQ-020 SHIFT after the last pair has been emitted, with HOLD empty: edge SHALL set Q to idle, FRAME=0, and enter IDLE. This is an underrun.
REQ-021 Acceptance into HOLD and transfer out of HOLD SHALL NOT coincide, because READY is low while HOLD is full. HOLD frees on the transfer edge, and READY rises the following cycle.
REQ-022 Latency from the accept edge (IDLE, HOLD empty) to the edge that presents pair 0 on Q SHALL be 1 cycle. A word therefore occupies Q for WIDTH/2 consecutive cycles.
REQ-023 Sustained throughput SHALL be one word per WIDTH/2 cycles when DATA_VALID is held high.
REQ-024 E low SHALL freeze Q, FRAME, BUSY, SHR, HOLD, counter and FSM at their current values. E rising SHALL resume exactly where operation stopped, with no pair lost or repeated.
REQ-025 R low SHALL take priority over E.

Reset
REQ-026 On any rising edge with R=0: Q={IDLE_LEVEL,IDLE_LEVEL}, FRAME=0, BUSY=0, HOLD_full=0, counter=0, FSM=IDLE.
REQ-027 Reset mid-word SHALL discard the partial word and any HOLD contents. After R returns high, the first output is the next accepted word's pair 0.
REQ-028 DATA_READY SHALL be 0 while R=0.
REQ-029 Power-up register state is undefined; reset is required before use.

Verification (WIDTH=8, IDLE_LEVEL=0)
REQ-030 Single word: accept 8'hB4 from IDLE -> following cycles Q=00,01,11,10 (pairs of 1011_0100 LSB-first: 00,01,11,10); FRAME high on first only; then Q=00, BUSY=0.
REQ-031 Back-to-back: DATA_VALID held high with 8'hB4 then 8'h1E -> 8 consecutive pairs 00,01,11,10,10,11,01,00; no idle pair; FRAME high on pairs 0 and 4.
REQ-032 Backpressure: DATA_VALID held high continuously -> DATA_READY pattern repeats every 4 cycles; no word is dropped or duplicated across 16 words.
REQ-033 Enable stall: deassert E for 3 cycles after pair 1 of 8'hB4 -> Q stays 01 for 3 cycles; then 11,10 follow.
REQ-034 Reset mid-word: R=0 for one edge after pair 2 -> Q=00, BUSY=0, DATA_READY=0 during reset; next accepted 8'hFF -> Q=11 x4.
REQ-035 Underrun: second word offered 2 cycles after first word's last pair -> exactly 2 idle pairs (00) between the words; FRAME high on first pair of each word.
